lab3_serial_addsub: RTL and testbench

// - Bit-serial adder/subtractor, the sequential counterpart of the lab2 half-subtractor cells.
// - Loads two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first,

---
 rtl/lab3_serial_addsub_pkg.sv | 16 +
 rtl/fa_cell.sv | 22 ++
 rtl/lab3_serial_addsub.sv | 107 ++++++++++
 tb/tb_lab3_serial_addsub.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lab3_serial_addsub_pkg.sv
// Shared definitions for the lab3 bit-serial adder/subtractor.
// Holds the FSM state encoding and the counter width helper.
package lab3_serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter only has to reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder assembled from two half-adder stages,
// mirroring the lab2 cells.
module fa_cell (
  output logic s,
  output logic c_out,
  input  logic x,
  input  logic y,
  input  logic c_in
);

  logic p1;
  logic g1;
  logic g2;

  // First half adder combines the operand bits, second folds in the carry.
  assign p1    = x ^ y;
  assign g1    = x & y;
  assign s     = p1 ^ c_in;
  assign g2    = p1 & c_in;
  assign c_out = g1 | g2;

endmodule

// File: rtl/lab3_serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop,
// LSB first, with a registered parallel result and a one-cycle done pulse.
module lab3_serial_addsub
  import lab3_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    count;
  logic             carry;
  logic             s_bit;
  logic             c_bit;

  fa_cell u_fa (
    .s     (s_bit),
    .c_out (c_bit),
    .x     (ra[0]),
    .y     (rb[0]),
    .c_in  (carry)
  );

  assign sr_next = {s_bit, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_SHIFT;
      ST_SHIFT: if (count == LAST) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert b at load time and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      sr     <= '0;
      count  <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          carry <= c_bit;
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          sr    <= sr_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= sr_next;
            cout   <= c_bit;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_serial_addsub.sv
// Self-checking bench for lab3_serial_addsub (WIDTH=4) against a plain
// arithmetic reference model.
module tb_lab3_serial_addsub;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;
  logic         done;

  int n_checks;
  int n_fail;
  int cyc;

  lab3_serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .result (result),
    .cout   (cout),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2^W.
  function automatic void model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c);
    int full;
    if (s) begin
      full = int'(x) - int'(y);
      r    = W'(full);
      c    = (x >= y);
    end else begin
      full = int'(x) + int'(y);
      r    = W'(full);
      c    = (full >= (1 << W));
    end
  endfunction

  task automatic apply_stimulus(input logic s_in, input logic [W-1:0] x, input logic [W-1:0] y,
                                input string tag);
    int           edges;
    int           busy_cycles;
    logic [W-1:0] exp_r;
    logic         exp_c;
    model(s_in, x, y, exp_r, exp_c);
    @(negedge clk);
    sub = s_in; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sub = 1'($urandom); a = W'($urandom); b = W'($urandom);
    edges = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && edges <= W + 6) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      edges++;
    end
    check_output({tag, " latency"}, edges, W + 1);
    check_output({tag, " busy_cycles"}, busy_cycles, W);
    check_output({tag, " result"}, result, exp_r);
    check_output({tag, " cout"}, cout, exp_c);
    check_output({tag, " busy_at_done"}, busy, 0);
    @(negedge clk);
    check_output({tag, " done_width"}, done, 0);
  endtask

  initial begin
    int           n_done;
    int           waited;
    int           done_cyc[3];
    logic [W-1:0] cap_r;
    logic         cap_c;

    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_output("reset result", result, 0);
    check_output("reset cout", cout, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    rst = 1'b0;

    $display("[TB] directed add/sub cases");
    apply_stimulus(1'b0, 4'd5, 4'd3, "add5+3");
    apply_stimulus(1'b0, 4'd9, 4'd8, "add9+8");
    apply_stimulus(1'b0, 4'd15, 4'd15, "add15+15");
    apply_stimulus(1'b1, 4'd3, 4'd5, "sub3-5");
    apply_stimulus(1'b1, 4'd7, 4'd7, "sub7-7");

    $display("[TB] start pulsed during SHIFT");
    @(negedge clk);
    sub = 1'b0; a = 4'd5; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 4'd1; b = 4'd1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    cap_r = '0;
    cap_c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        n_done++;
        cap_r = result;
        cap_c = cout;
      end
      @(negedge clk);
    end
    check_output("ignore_start done_count", n_done, 1);
    check_output("ignore_start result", cap_r, 8);
    check_output("ignore_start cout", cap_c, 0);

    $display("[TB] reset during SHIFT");
    @(negedge clk);
    sub = 1'b0; a = 4'd9; b = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort busy", busy, 0);
    check_output("abort done", done, 0);
    check_output("abort result", result, 0);
    check_output("abort cout", cout, 0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    check_output("abort no_done", n_done, 0);
    apply_stimulus(1'b0, 4'd6, 4'd1, "after_abort add6+1");

    $display("[TB] start held high");
    @(negedge clk);
    sub = 1'b0; a = 4'd2; b = 4'd3; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check_output("held_start done_seen", (waited < 20), 1);
      check_output("held_start result", result, 5);
      done_cyc[k] = cyc;
      if (k == 2) start = 1'b0;
      @(negedge clk);
    end
    check_output("held_start period1", done_cyc[1] - done_cyc[0], W + 2);
    check_output("held_start period2", done_cyc[2] - done_cyc[1], W + 2);
    @(negedge clk);
    @(negedge clk);
    check_output("held_start idle_busy", busy, 0);

    $display("[TB] exhaustive add and sub");
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          apply_stimulus(1'(s), W'(x), W'(y), (s != 0) ? "exh_sub" : "exh_add");

    $display("[TB] random operations with idle gaps");
    for (int i = 0; i < 20; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(negedge clk);
      apply_stimulus(1'($urandom), W'($urandom), W'($urandom), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
